hazard_scoreboard: RTL and testbench

//  Parametrised hazard unit for the 5-stage pipeline with a multi-cycle MUL/DIV unit hanging off EX.

---
 rtl/hazard_pkg.sv | 12 +
 rtl/hazard_fwd_sel.sv | 61 ++++++
 rtl/hazard_scoreboard.sv | 141 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types for the pipeline hazard unit
package hazard_pkg;

    // Operand source select driven onto the EX-stage SrcA/SrcB muxes.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,  // register file value from ID/EX
        FWD_WB  = 2'b01,  // WB-stage result
        FWD_MEM = 2'b10,  // ALUResultM
        FWD_MD  = 2'b11   // MUL/DIV result, valid on the MdDone cycle
    } fwd_sel_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// rtl/hazard_fwd_sel.sv - per-operand forwarding select and stall request
//
// Purpose: compares one EX source register against every producer that may
// still hold a newer value and picks the forwarding source, or requests a
// stall when the value cannot be forwarded yet.
// Ports:
//   rs           source register of the EX instruction
//   rd_m, rd_w   destinations in MEM / WB
//   pend_rd      destination of the in-flight MUL/DIV op
//   reg_write_m, reg_write_w, load_m   MEM/WB write enables and MEM load flag
//   md_busy, md_done                   MUL/DIV scoreboard state
//   sel          forwarding select (fwd_sel_e encoding)
//   stall_req    operand cannot be supplied this cycle
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int RW = 5
) (
    input  logic [RW-1:0] rs,
    input  logic [RW-1:0] rd_m,
    input  logic [RW-1:0] rd_w,
    input  logic [RW-1:0] pend_rd,
    input  logic          reg_write_m,
    input  logic          reg_write_w,
    input  logic          load_m,
    input  logic          md_busy,
    input  logic          md_done,
    output logic [1:0]    sel,
    output logic          stall_req
);

    fwd_sel_e sel_e;
    logic     rs_nz;
    logic     hit_md;
    logic     hit_m;
    logic     hit_w;

    always_comb begin
        // x0 is hardwired to zero, so it never matches any producer.
        rs_nz  = |rs;
        hit_md = rs_nz && (rs == pend_rd);
        hit_m  = rs_nz && reg_write_m && (rs == rd_m);
        hit_w  = rs_nz && reg_write_w && (rs == rd_w);

        sel_e = FWD_RF;
        if (md_done && hit_md) begin
            sel_e = FWD_MD;
        end else if (hit_m && !load_m) begin
            sel_e = FWD_MEM;
        end else if (hit_w) begin
            sel_e = FWD_WB;
        end

        // Load data is not available in MEM, and a pending MUL/DIV result
        // only appears on its done cycle: both must hold EX.
        stall_req = (hit_m && load_m) || (md_busy && !md_done && hit_md);
    end

    assign sel = sel_e;

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - pipeline hazard unit with MUL/DIV scoreboard
//
// Purpose: forwarding selects, load-use / MUL/DIV stalls, redirect flushes,
// a one-entry scoreboard for the multi-cycle MUL/DIV unit, and a saturating
// stall-cycle performance counter.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   Rs1E, Rs2E, RdE, MdStartE  EX instruction sources, dest, MUL/DIV flag
//   RdM, RdW, RegWriteM, RegWriteW, LoadM   MEM/WB producer info
//   PCSrc                      redirect taken in EX
//   ForwardA, ForwardB         SrcA/SrcB forwarding selects
//   StallE, BubbleM            hold front end / insert NOP into EX/MEM
//   FlushD, FlushE             clear IF/ID / ID/EX
//   MdBusy, MdDone             MUL/DIV in flight / result valid this cycle
//   StallCount                 saturating count of stall cycles
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter  int NREG   = 32,
    parameter  int MD_LAT = 4,
    parameter  int CNT_W  = 16,
    localparam int RW     = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [RW-1:0]    Rs1E,
    input  logic [RW-1:0]    Rs2E,
    input  logic [RW-1:0]    RdE,
    input  logic             MdStartE,
    input  logic [RW-1:0]    RdM,
    input  logic [RW-1:0]    RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             LoadM,
    input  logic             PCSrc,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic             StallE,
    output logic             BubbleM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             MdBusy,
    output logic             MdDone,
    output logic [CNT_W-1:0] StallCount
);

    localparam int CW = $clog2(MD_LAT);

    logic             md_busy_q, md_busy_d;
    logic [CW-1:0]    md_cnt_q, md_cnt_d;
    logic [RW-1:0]    pend_rd_q, pend_rd_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic md_done;
    logic stall_a;
    logic stall_b;
    logic stall;
    logic md_accept;

    assign md_done = md_busy_q && (md_cnt_q == '0);

    hazard_fwd_sel #(.RW(RW)) u_fwd_a (
        .rs          (Rs1E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .pend_rd     (pend_rd_q),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .load_m      (LoadM),
        .md_busy     (md_busy_q),
        .md_done     (md_done),
        .sel         (ForwardA),
        .stall_req   (stall_a)
    );

    hazard_fwd_sel #(.RW(RW)) u_fwd_b (
        .rs          (Rs2E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .pend_rd     (pend_rd_q),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .load_m      (LoadM),
        .md_busy     (md_busy_q),
        .md_done     (md_done),
        .sel         (ForwardB),
        .stall_req   (stall_b)
    );

    always_comb begin
        // A new MUL/DIV cannot enter while the unit is still working, but
        // may enter on the done cycle since the unit frees up at that edge.
        stall     = stall_a || stall_b || (MdStartE && md_busy_q && !md_done);
        md_accept = MdStartE && !stall && !PCSrc;

        md_busy_d   = md_busy_q;
        md_cnt_d    = md_cnt_q;
        pend_rd_d   = pend_rd_q;
        stall_cnt_d = stall_cnt_q;

        // Redirects never cancel an in-flight op: it is older than the branch.
        if (md_accept) begin
            md_busy_d = 1'b1;
            md_cnt_d  = CW'(MD_LAT - 1);
            pend_rd_d = RdE;
        end else if (md_busy_q) begin
            if (md_cnt_q == '0) begin
                md_busy_d = 1'b0;
            end else begin
                md_cnt_d = md_cnt_q - CW'(1);
            end
        end

        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_busy_q   <= 1'b0;
            md_cnt_q    <= '0;
            pend_rd_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            md_busy_q   <= md_busy_d;
            md_cnt_q    <= md_cnt_d;
            pend_rd_q   <= pend_rd_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallE     = stall;
    assign BubbleM    = stall;
    assign FlushD     = PCSrc;
    assign FlushE     = PCSrc || stall;
    assign MdBusy     = md_busy_q;
    assign MdDone     = md_done;
    assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

    localparam int NREG   = 32;
    localparam int MD_LAT = 4;
    localparam int CNT_W  = 4;
    localparam int RW     = 5;

    logic             clk;
    logic             rst_n;
    logic [RW-1:0]    Rs1E, Rs2E, RdE, RdM, RdW;
    logic             MdStartE, RegWriteM, RegWriteW, LoadM, PCSrc;
    logic [1:0]       ForwardA, ForwardB;
    logic             StallE, BubbleM, FlushD, FlushE, MdBusy, MdDone;
    logic [CNT_W-1:0] StallCount;

    int n_cmp = 0;
    int n_err = 0;

    hazard_scoreboard #(.NREG(NREG), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .MdStartE   (MdStartE),
        .RdM        (RdM),
        .RdW        (RdW),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .LoadM      (LoadM),
        .PCSrc      (PCSrc),
        .ForwardA   (ForwardA),
        .ForwardB   (ForwardB),
        .StallE     (StallE),
        .BubbleM    (BubbleM),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .MdBusy     (MdBusy),
        .MdDone     (MdDone),
        .StallCount (StallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
        MdStartE = 0; RegWriteM = 0; RegWriteW = 0; LoadM = 0; PCSrc = 0;
    endtask

    // Advance one clock edge; inputs are changed right after the falling edge.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #2;
        chk("rst_fwd_a",   ForwardA,   2'b00);
        chk("rst_fwd_b",   ForwardB,   2'b00);
        chk("rst_stall",   StallE,     1'b0);
        chk("rst_bubble",  BubbleM,    1'b0);
        chk("rst_flushd",  FlushD,     1'b0);
        chk("rst_flushe",  FlushE,     1'b0);
        chk("rst_busy",    MdBusy,     1'b0);
        chk("rst_done",    MdDone,     1'b0);
        chk("rst_scount",  StallCount, 4'd0);
        next_cycle();
        rst_n = 1'b1;

        // Forwarding from MEM, WB, priority, and x0.
        next_cycle();
        RdM = 5; RegWriteM = 1; Rs1E = 5; #1;
        chk("fwd_mem_a", ForwardA, 2'b10);
        chk("fwd_mem_stall", StallE, 1'b0);
        RegWriteM = 0; RdM = 0; RdW = 5; RegWriteW = 1; #1;
        chk("fwd_wb_a", ForwardA, 2'b01);
        RdM = 5; RegWriteM = 1; #1;
        chk("fwd_mem_over_wb", ForwardA, 2'b10);
        Rs2E = 5; #1;
        chk("fwd_mem_b", ForwardB, 2'b10);
        idle(); RdM = 0; RegWriteM = 1; RdW = 0; RegWriteW = 1; #1;
        chk("fwd_x0_a", ForwardA, 2'b00);

        // Load-use on Rs2, then forwarded from WB.
        next_cycle();
        idle(); LoadM = 1; RegWriteM = 1; RdM = 7; Rs2E = 7; #1;
        chk("lu_stall",  StallE,  1'b1);
        chk("lu_bubble", BubbleM, 1'b1);
        chk("lu_flushe", FlushE,  1'b1);
        chk("lu_flushd", FlushD,  1'b0);
        chk("lu_fwd_b",  ForwardB, 2'b00);
        next_cycle();
        idle(); RdW = 7; RegWriteW = 1; Rs2E = 7; #1;
        chk("lu_after_fwd_b", ForwardB, 2'b01);
        chk("lu_after_stall", StallE, 1'b0);
        chk("lu_scount", StallCount, 4'd1);
        idle(); LoadM = 1; RegWriteM = 1; RdM = 0; Rs2E = 0; #1;
        chk("lu_x0_stall", StallE, 1'b0);

        // MUL/DIV issue to x9 followed by a dependent instruction.
        next_cycle();
        idle(); MdStartE = 1; RdE = 9; #1;
        chk("md_issue_stall", StallE, 1'b0);
        next_cycle();
        idle(); Rs1E = 9; #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("md_raw_stall%0d", i), StallE, 1'b1);
            chk($sformatf("md_raw_busy%0d", i),  MdBusy, 1'b1);
            chk($sformatf("md_raw_ndone%0d", i), MdDone, 1'b0);
            next_cycle(); #1;
        end
        chk("md_done",      MdDone,   1'b1);
        chk("md_fwd_a",     ForwardA, 2'b11);
        chk("md_done_stall", StallE,  1'b0);
        chk("md_scount",    StallCount, 4'd4);
        next_cycle();
        idle(); #1;
        chk("md_idle_busy", MdBusy, 1'b0);

        // Structural stall: second MUL/DIV issues on the first one's done edge.
        next_cycle();
        idle(); MdStartE = 1; RdE = 3; #1;
        next_cycle();
        idle(); MdStartE = 1; RdE = 4; #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("st_stall%0d", i), StallE, 1'b1);
            chk($sformatf("st_busy%0d", i),  MdBusy, 1'b1);
            next_cycle(); #1;
        end
        chk("st_done",       MdDone, 1'b1);
        chk("st_done_stall", StallE, 1'b0);
        chk("st_scount",     StallCount, 4'd7);
        next_cycle();
        idle(); Rs1E = 4; #1;
        chk("st_busy_cont", MdBusy, 1'b1);
        chk("st_ndone",     MdDone, 1'b0);
        chk("st_raw2",      StallE, 1'b1);
        next_cycle(); #1;
        next_cycle(); #1;
        next_cycle(); #1;
        chk("st_done2",   MdDone,   1'b1);
        chk("st_fwd2",    ForwardA, 2'b11);
        chk("st_scount2", StallCount, 4'd10);

        // Redirect during a load-use stall with a MUL/DIV in flight.
        next_cycle();
        idle(); MdStartE = 1; RdE = 12; #1;
        next_cycle();
        idle(); LoadM = 1; RegWriteM = 1; RdM = 7; Rs1E = 7; PCSrc = 1; #1;
        chk("br_stall",  StallE, 1'b1);
        chk("br_flushd", FlushD, 1'b1);
        chk("br_flushe", FlushE, 1'b1);
        next_cycle();
        idle(); #1;
        chk("br_ndone_a", MdDone, 1'b0);
        next_cycle(); #1;
        chk("br_ndone_b", MdDone, 1'b0);
        next_cycle(); #1;
        chk("br_md_done", MdDone, 1'b1);
        chk("br_scount",  StallCount, 4'd11);
        next_cycle();
        idle(); MdStartE = 1; RdE = 13; PCSrc = 1; #1;
        chk("br_issue_flushe", FlushE, 1'b1);
        chk("br_issue_stall",  StallE, 1'b0);
        next_cycle();
        idle(); #1;
        chk("br_no_accept", MdBusy, 1'b0);

        // Asynchronous reset in the middle of a MUL/DIV op.
        next_cycle();
        idle(); MdStartE = 1; RdE = 9; #1;
        next_cycle();
        idle(); #1;
        chk("ar_busy_before", MdBusy, 1'b1);
        rst_n = 1'b0; #1;
        chk("ar_busy",   MdBusy, 1'b0);
        chk("ar_scount", StallCount, 4'd0);
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            next_cycle(); #1;
            chk($sformatf("ar_ndone%0d", i), MdDone, 1'b0);
        end

        // Saturation of the stall counter over 2^CNT_W+3 stall cycles.
        next_cycle();
        idle(); LoadM = 1; RegWriteM = 1; RdM = 7; Rs1E = 7; #1;
        chk("sat_start", StallCount, 4'd0);
        for (int i = 1; i <= (1 << CNT_W) + 3; i++) begin
            next_cycle(); #1;
            if (i == 14) chk("sat_14", StallCount, 4'd14);
            if (i == 15) chk("sat_15", StallCount, 4'd15);
        end
        chk("sat_hold", StallCount, 4'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
